// File: rtl/counter_pkg.sv
// counter_pkg: definitions shared by the counter family.
//   MODE_WRAP / MODE_SAT : values for a counter's SATURATE parameter
//   clamp_load()         : limits a parallel-load value to the legal count range
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Values above the top of the count range load as the top count (modulus-1).
    function automatic int unsigned clamp_load(input int unsigned val,
                                               input int unsigned modulus);
        return (val >= modulus) ? modulus - 1 : val;
    endfunction

endpackage

// File: rtl/counter_mod_n.sv
// counter_mod_n: modulo-MOD up/down counter with enable, synchronous clear,
// clamped parallel load, wrap or saturate behaviour at the bounds, a
// registered terminal-count pulse and a count of wrap events.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   i_en        count enable, one step per cycle
//   i_up        direction, 1 = up, 0 = down
//   i_clear     synchronous clear (highest priority)
//   i_load      synchronous parallel load of i_load_val (clamped to MOD-1)
//   i_load_val  load value
//   o_cnt       current count, 0..MOD-1
//   o_tc        one-cycle pulse in the cycle o_cnt shows a wrapped value
//   o_sat       high while held at the bound of the current direction (SATURATE=1)
//   o_wrap_cnt  wrap events since reset/clear, modulo 2^WRAP_W
module counter_mod_n
    import counter_pkg::*;
#(
    parameter int MOD      = 100,
    parameter int CW       = $clog2(MOD),
    parameter int SATURATE = MODE_WRAP,
    parameter int WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_en,
    input  logic              i_up,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [CW-1:0]     i_load_val,
    output logic [CW-1:0]     o_cnt,
    output logic              o_tc,
    output logic              o_sat,
    output logic [WRAP_W-1:0] o_wrap_cnt
);

    localparam logic [CW-1:0] CNT_MAX  = CW'(MOD - 1);
    localparam bit            SAT_MODE = (SATURATE == MODE_SAT);

    logic [CW-1:0]     bound;
    logic              at_bound;
    logic [CW-1:0]     cnt_nxt;
    logic              tc_nxt;
    logic              sat_nxt;
    logic [WRAP_W-1:0] wrap_nxt;

    // Bound in the direction of travel; explicit compare keeps non-power-of-two MOD exact.
    always_comb begin
        bound    = i_up ? CNT_MAX : '0;
        at_bound = (o_cnt == bound);
    end

    always_comb begin
        cnt_nxt  = o_cnt;
        tc_nxt   = 1'b0;
        wrap_nxt = o_wrap_cnt;
        if (i_clear) begin
            cnt_nxt  = '0;
            wrap_nxt = '0;
        end else if (i_load) begin
            cnt_nxt = CW'(clamp_load(32'(i_load_val), unsigned'(MOD)));
        end else if (i_en) begin
            if (at_bound) begin
                // Saturate mode simply keeps the held value.
                if (!SAT_MODE) begin
                    cnt_nxt  = i_up ? '0 : CNT_MAX;
                    tc_nxt   = 1'b1;
                    wrap_nxt = o_wrap_cnt + 1'b1;
                end
            end else begin
                cnt_nxt = i_up ? o_cnt + 1'b1 : o_cnt - 1'b1;
            end
        end
        // o_sat follows the next count against the current direction's bound,
        // so it also drops when i_up reverses while holding; clear forces it low.
        sat_nxt = SAT_MODE && !i_clear && (cnt_nxt == bound);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_cnt      <= '0;
            o_tc       <= 1'b0;
            o_sat      <= 1'b0;
            o_wrap_cnt <= '0;
        end else begin
            o_cnt      <= cnt_nxt;
            o_tc       <= tc_nxt;
            o_sat      <= sat_nxt;
            o_wrap_cnt <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_counter_mod_n.sv
// tb_counter_mod_n: scoreboard bench for counter_mod_n. Three instances
// (MOD=100 wrap, MOD=100 saturate, MOD=2 wrap with a 2-bit wrap counter)
// share the control inputs; an arithmetic reference model predicts each
// instance's outputs and a monitor compares them after every clock edge.
module tb_counter_mod_n;

    typedef struct {
        int unsigned cnt;
        bit          tc;
        bit          sat;
        int unsigned wrap;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic en, up, clr, ld;
    logic [6:0] lv7;
    logic [0:0] lv1;

    logic [6:0] cnt_a, cnt_b;
    logic [0:0] cnt_c;
    logic       tc_a, tc_b, tc_c, sat_a, sat_b, sat_c;
    logic [7:0] wrap_a, wrap_b;
    logic [1:0] wrap_c;

    int checks = 0;
    int errors = 0;

    int unsigned md[3] = '{100, 100, 2};
    bit          sm[3] = '{1'b0, 1'b1, 1'b0};
    int unsigned wm[3] = '{256, 256, 4};
    exp_t        mdl[3];
    exp_t        sq[3][$];

    always #5 clk = ~clk;

    counter_mod_n #(.MOD(100), .SATURATE(0), .WRAP_W(8)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .i_en(en), .i_up(up), .i_clear(clr),
        .i_load(ld), .i_load_val(lv7), .o_cnt(cnt_a), .o_tc(tc_a),
        .o_sat(sat_a), .o_wrap_cnt(wrap_a));

    counter_mod_n #(.MOD(100), .SATURATE(1), .WRAP_W(8)) dut_sat (
        .clk(clk), .reset_n(reset_n), .i_en(en), .i_up(up), .i_clear(clr),
        .i_load(ld), .i_load_val(lv7), .o_cnt(cnt_b), .o_tc(tc_b),
        .o_sat(sat_b), .o_wrap_cnt(wrap_b));

    counter_mod_n #(.MOD(2), .SATURATE(0), .WRAP_W(2)) dut_m2 (
        .clk(clk), .reset_n(reset_n), .i_en(en), .i_up(up), .i_clear(clr),
        .i_load(ld), .i_load_val(lv1), .o_cnt(cnt_c), .o_tc(tc_c),
        .o_sat(sat_c), .o_wrap_cnt(wrap_c));

    // Reference model: one clock edge of a modulo-m counter, in plain arithmetic.
    function automatic exp_t step(exp_t s, int unsigned m, bit sat_mode,
                                  int unsigned wmod, bit e, bit u, bit c,
                                  bit l, int unsigned v);
        exp_t        n;
        int unsigned top;
        n   = s;
        top = m - 1;
        n.tc = 1'b0;
        if (c) begin
            n.cnt  = 0;
            n.wrap = 0;
            n.sat  = 1'b0;
            return n;
        end
        if (l) begin
            n.cnt = (v > top) ? top : v;
        end else if (e) begin
            if (sat_mode) begin
                if (u) n.cnt = (s.cnt < top) ? s.cnt + 1 : top;
                else   n.cnt = (s.cnt > 0) ? s.cnt - 1 : 0;
            end else begin
                if ((u && s.cnt == top) || (!u && s.cnt == 0)) begin
                    n.tc   = 1'b1;
                    n.wrap = (s.wrap + 1) % wmod;
                end
                n.cnt = u ? (s.cnt + 1) % m : (s.cnt + m - 1) % m;
            end
        end
        n.sat = sat_mode && (n.cnt == (u ? top : 0));
        return n;
    endfunction

    function automatic exp_t actual(int k);
        exp_t a;
        case (k)
            0: begin a.cnt = cnt_a; a.tc = tc_a; a.sat = sat_a; a.wrap = wrap_a; end
            1: begin a.cnt = cnt_b; a.tc = tc_b; a.sat = sat_b; a.wrap = wrap_b; end
            default: begin a.cnt = cnt_c; a.tc = tc_c; a.sat = sat_c; a.wrap = wrap_c; end
        endcase
        return a;
    endfunction

    task automatic cmp(string nm, int unsigned act, int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all(int k, exp_t e, string tag);
        exp_t a;
        a = actual(k);
        cmp($sformatf("%s dut%0d o_cnt", tag, k), a.cnt, e.cnt);
        cmp($sformatf("%s dut%0d o_tc", tag, k), a.tc, e.tc);
        cmp($sformatf("%s dut%0d o_sat", tag, k), a.sat, e.sat);
        cmp($sformatf("%s dut%0d o_wrap_cnt", tag, k), a.wrap, e.wrap);
    endtask

    // Monitor: every instance presents a result after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (sq[k].size() > 0) begin
                    exp_t e;
                    e = sq[k].pop_front();
                    compare_all(k, e, "edge");
                end
            end
        end
    end

    task automatic drive(bit e, bit u, bit c, bit l, int unsigned v);
        int unsigned vk;
        @(negedge clk);
        en  = e;
        up  = u;
        clr = c;
        ld  = l;
        lv7 = 7'(v);
        lv1 = 1'(v);
        for (int k = 0; k < 3; k++) begin
            vk = (k == 2) ? (v & 1) : (v & 127);
            mdl[k] = step(mdl[k], md[k], sm[k], wm[k], e, u, c, l, vk);
            sq[k].push_back(mdl[k]);
        end
    endtask

    task automatic idle_inputs();
        en  = 1'b0;
        up  = 1'b1;
        clr = 1'b0;
        ld  = 1'b0;
        lv7 = '0;
        lv1 = '0;
    endtask

    // Reset asserted between edges must clear everything without a clock edge.
    task automatic async_reset();
        @(posedge clk);
        #3;
        idle_inputs();
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            mdl[k] = '{cnt: 0, tc: 1'b0, sat: 1'b0, wrap: 0};
            sq[k].delete();
            compare_all(k, mdl[k], "async_reset");
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic random_run(int n);
        int unsigned r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 63);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  r == 0, (r >= 1 && r <= 4), $urandom_range(0, 127));
        end
    endtask

    initial begin
        idle_inputs();
        for (int k = 0; k < 3; k++) mdl[k] = '{cnt: 0, tc: 1'b0, sat: 1'b0, wrap: 0};
        #50;
        for (int k = 0; k < 3; k++) compare_all(k, mdl[k], "reset");
        #50;
        reset_n = 1'b1;

        // Two full wraps up (MOD=2 instance wraps every other cycle).
        repeat (205) drive(1'b1, 1'b1, 1'b0, 1'b0, 0);
        // Clear, then count down from 0.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
        // Direction change at 50 takes effect on the same edge.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 50);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 0);
        // Clamped load, then clear beating load.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 120);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 42);
        // Climb into the top bound from 97, then reverse.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 97);
        repeat (4) drive(1'b1, 1'b1, 1'b0, 1'b0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0);

        random_run(1500);

        // Reset mid-count at 37.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 35);
        repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b0, 0);
        async_reset();

        random_run(500);

        @(negedge clk);
        @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_mod_n.md
Name: counter_mod_n

Overview:
- Parametrised successor to the fixed modulo-100 counter.
- Modulo-MOD counter with count enable, up/down direction, synchronous clear, parallel load, and wrap or saturate mode.
- Emits a registered terminal-count pulse and a wrap-event counter, so instances can be cascaded (e.g. seconds/minutes timebases) and used as general event counters.

Parameters:
MOD, 100, counter modulus; count range 0..MOD-1; legal MOD >= 2
CW, $clog2(MOD), width of o_cnt (7 for MOD=100)
SATURATE, 0, 0 = wrap at bounds, 1 = hold at bounds
WRAP_W, 8, width of the wrap-event counter

Ports:
clk  input  1  system clock; all state on rising edge
reset_n  input  1  asynchronous, active-low reset
i_en  input  1  count enable; one step per cycle while high
i_up  input  1  direction: 1 = up, 0 = down
i_clear  input  1  synchronous clear to 0
i_load  input  1  synchronous parallel load
i_load_val  input  CW  load value
o_cnt  output  CW  current count, registered
o_tc  output  1  one-cycle registered pulse on a wrap event
o_sat  output  1  registered level; high while saturated at a bound (SATURATE=1 only)
o_wrap_cnt  output  WRAP_W  number of wrap events since reset/clear, modulo 2^WRAP_W

Behaviour:
- Reset (reset_n low, asynchronous, any time): o_cnt=0, o_tc=0, o_sat=0, o_wrap_cnt=0. Effective immediately, without waiting for a clock edge.
- First count edge after deassertion is the first rising clk edge with reset_n high.
- Per-edge priority: i_clear > i_load > i_en count > hold.
- i_clear: o_cnt=0, o_wrap_cnt=0, o_tc=0, o_sat=0. Applies regardless of i_en.
- i_load: o_cnt = i_load_val if i_load_val <= MOD-1, else MOD-1 (clamped). o_tc=0. o_wrap_cnt unchanged. o_sat is recomputed (see saturate mode).
- Count up, wrap mode: o_cnt=MOD-1 -> 0; otherwise +1.
- Count down, wrap mode: o_cnt=0 -> MOD-1; otherwise -1.
- Wrap event, in either direction:
  - o_tc=1 for exactly the cycle in which o_cnt shows the wrapped value (0 or MOD-1).
  - o_wrap_cnt increments on the same edge; it rolls 2^WRAP_W-1 -> 0 silently.
- Saturate mode (SATURATE=1):
  - Up at MOD-1 and down at 0 both hold o_cnt. No o_tc pulse; o_wrap_cnt stays 0.
  - o_sat=1 whenever the next state equals the bound in the current i_up direction (MOD-1 for up, 0 for down).
  - o_sat clears on the first edge that moves o_cnt away from the bound or reverses i_up.
- i_en low: o_cnt holds; o_tc returns to 0 on the next edge.
- o_tc is never high for two consecutive cycles unless MOD=2 with i_en held high (a wrap every cycle).
- Direction change takes effect on the same edge; there is no pipeline.
- Latency: input to o_cnt is 1 cycle; all outputs are registered, with no combinational input-to-output path.
- Arithmetic: compare against MOD-1 at width CW. No reliance on natural 2^CW overflow, so non-power-of-two MOD is exact.

Decomposition:
- Shared package counter_pkg holds:
  - localparams MODE_WRAP=0 and MODE_SAT=1;
  - a function clamp_load(val, MOD) used by all counter variants.
- No sub-module: a single always block per register group. The wrap counter stays inline, because cascading is done at the instance level (o_tc of one instance drives i_en of the next).

Test Plan:
1. Reset release at 100 ns, then i_en=1, i_up=1, MOD=100 -> o_cnt counts 0..99. On the edge after 99, o_cnt=0, o_tc=1 for one cycle, o_wrap_cnt=1. After 2000 ns, o_wrap_cnt=2.
2. i_up=0 from o_cnt=0 -> o_cnt=99 with an o_tc pulse. Toggle i_up at o_cnt=50 -> next value is 51 (direction change on the same edge).
3. i_load=1, i_load_val=120 -> o_cnt=99 (clamped). Simultaneous i_clear=1, i_load=1, i_load_val=42 -> o_cnt=0, o_wrap_cnt=0.
4. SATURATE=1, count up from 97 -> 98, 99, 99, 99. o_sat=1 in the same cycle o_cnt first reads 99. No o_tc; o_wrap_cnt=0. Set i_up=0 -> o_cnt=98, o_sat=0.
5. Assert reset_n low mid-count (o_cnt=37) between clock edges -> o_cnt=0, o_tc=0, o_wrap_cnt=0 immediately, without waiting for a clock edge.
6. MOD=2, WRAP_W=2, i_en held high -> o_cnt alternates 1, 0, and o_tc=1 on every 0. o_wrap_cnt runs 1, 2, 3, 0 (rollover).
